// File: rtl/aes_pkg.sv
// Shared AES constants, types and GF(2^8) helpers.
// Used by the iterative MixColumns slice.
package aes_pkg;

   localparam int NCOL = 4;
   localparam int BW = 8;
   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef logic [127:0] state_t;
   typedef logic [31:0] word_t;
   typedef logic [BW-1:0] byte_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fsm_t;

   function automatic byte_t xtime(input byte_t b);
      return {b[BW-2:0], 1'b0} ^ (b[BW-1] ? AES_POLY : '0);
   endfunction

endpackage

// File: rtl/mix_columns_iter_if.sv
// Valid/ready bundle between shift_rows, MixColumns and downstream.
// The inv bit exists only when MIX_COLUMNS_INV_EN is defined.
interface mix_columns_iter_if;
   import aes_pkg::*;

   logic   in_valid;
   logic   in_ready;
   state_t data_in;
   logic   out_valid;
   logic   out_ready;
   state_t data_out;
`ifdef MIX_COLUMNS_INV_EN
   logic   inv;

   modport master (
      output in_valid, data_in, out_ready, inv,
      input  in_ready, out_valid, data_out
   );
   modport slave (
      input  in_valid, data_in, out_ready, inv,
      output in_ready, out_valid, data_out
   );
`else
   modport master (
      output in_valid, data_in, out_ready,
      input  in_ready, out_valid, data_out
   );
   modport slave (
      input  in_valid, data_in, out_ready,
      output in_ready, out_valid, data_out
   );
`endif

endinterface

// File: rtl/mix_columns_iter_mix.sv
// Single-column (Inv)MixColumns over GF(2^8), purely combinational.
// Row-0 byte sits at the column MSB.
module mix_single_column
   import aes_pkg::*;
(
   input  word_t col_in,
`ifdef MIX_COLUMNS_INV_EN
   input  logic  inv,
`endif
   output word_t col_out
);

   byte_t a  [4];
   byte_t x2 [4];
   byte_t x4 [4];
   byte_t x8 [4];
   byte_t fwd [4];
   byte_t bwd [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         a[i]  = col_in[31-8*i -: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
      end
   end

   // Row r uses a rotated coefficient row, so index neighbours mod 4.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         fwd[r] = x2[r] ^ (x2[(r+1)%4] ^ a[(r+1)%4])
                ^ a[(r+2)%4] ^ a[(r+3)%4];
         bwd[r] = (x8[r] ^ x4[r] ^ x2[r])
                ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
      end
   end

   always_comb begin
      col_out = '0;
      for (int r = 0; r < 4; r++) begin
`ifdef MIX_COLUMNS_INV_EN
         col_out[31-8*r -: 8] = inv ? bwd[r] : fwd[r];
`else
         col_out[31-8*r -: 8] = fwd[r];
`endif
      end
   end

`ifndef MIX_COLUMNS_INV_EN
   logic unused_bwd;
   always_comb begin
      unused_bwd = 1'b0;
      for (int r = 0; r < 4; r++) unused_bwd = unused_bwd ^ (^bwd[r]);
   end
`endif

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one column per cycle, valid/ready on both sides.
// Define MIX_COLUMNS_INV_EN to add the per-state inv select (InvMixColumns).
module mix_columns_iter
   import aes_pkg::*;
(
   input  logic clk,
   input  logic rst,
   mix_columns_iter_if.slave bus
);

   localparam int CW = $clog2(NCOL);

   fsm_t          state_q, state_d;
   logic [CW-1:0] col_cnt;
   state_t        st_q;
   word_t         col_in, col_out;
   logic          accept;
   logic          inv_q;

   assign accept = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = BUSY;
         BUSY: if (col_cnt == CW'(NCOL-1)) state_d = DONE;
         DONE: if (bus.out_ready) state_d = bus.in_valid ? BUSY : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.data_out  = '0;
      unique case (state_q)
         IDLE: bus.in_ready = 1'b1;
         BUSY: bus.in_ready = 1'b0;
         DONE: begin
            bus.in_ready  = bus.out_ready;
            bus.out_valid = 1'b1;
            bus.data_out  = st_q;
         end
         default: bus.in_ready = 1'b0;
      endcase
   end

   always_comb begin
      col_in = '0;
      for (int i = 0; i < NCOL; i++)
         if (col_cnt == CW'(i)) col_in = st_q[127-32*i -: 32];
   end

   // Counter only advances in BUSY, so its 3->0 wrap is the DONE edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q    <= '0;
         col_cnt <= '0;
         inv_q   <= 1'b0;
      end else if (accept) begin
         st_q    <= bus.data_in;
         col_cnt <= '0;
`ifdef MIX_COLUMNS_INV_EN
         inv_q   <= bus.inv;
`endif
      end else if (state_q == BUSY) begin
         for (int i = 0; i < NCOL; i++)
            if (col_cnt == CW'(i)) st_q[127-32*i -: 32] <= col_out;
         col_cnt <= col_cnt + 1'b1;
      end
   end

   mix_single_column u_mix (
      .col_in  (col_in),
`ifdef MIX_COLUMNS_INV_EN
      .inv     (inv_q),
`endif
      .col_out (col_out)
   );

`ifndef MIX_COLUMNS_INV_EN
   logic unused_inv;
   assign unused_inv = inv_q;
`endif

endmodule
